// File: rtl/segment_char_sequencer_if.sv
// segment_char_sequencer_if: pin strobe/char, animator handshake and FIFO status of the character sequencer.
interface segment_char_sequencer_if;
    logic       wr_strobe;
    logic [6:0] wr_char;
    logic       anim_ready;
    logic       char_valid;
    logic [6:0] char_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    modport master (output wr_strobe, wr_char, anim_ready,
                    input char_valid, char_out, fifo_full, fifo_empty, overflow);
    modport slave (input wr_strobe, wr_char, anim_ready,
                   output char_valid, char_out, fifo_full, fifo_empty, overflow);
endinterface

// File: rtl/segment_char_sequencer.sv
// segment_char_sequencer: FIFO-fed character scheduler holding each character for a dwell of tick60 frames.
// Define SEQ_LOOP_EN to re-offer the last character when the dwell expires with the FIFO empty.
module segment_char_sequencer #(
    parameter int DEPTH       = 4,
    parameter int DWELL_TICKS = 30,
    parameter int SYNC_STAGES = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     ena,
    input logic                     tick60,
    segment_char_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, ISSUE, ANIM1, ANIM, DWELL} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [6:0]             r_mem [DEPTH];
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [AW:0]            r_count;
    logic [7:0]             r_dwell;
    logic [6:0]             r_char;
    logic                   r_overflow;
    logic                   w_push, w_wr, w_pop, w_full, w_empty, w_dwell_clr, w_dwell_inc;
    assign w_push = ena & r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_full = r_count == (AW+1)'(DEPTH);
    assign w_empty = r_count == '0;
    // A push into a full FIFO still lands when the same cycle pops the head.
    assign w_wr = w_push & (~w_full | w_pop);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync     <= '0;
            r_sync_q   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_char     <= '0;
            r_overflow <= 1'b0;
            r_dwell    <= '0;
            r_state    <= IDLE;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.wr_strobe};
            r_sync_q <= r_sync[SYNC_STAGES-1];
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_char <= r_mem[r_rptr];
            end
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
            r_dwell <= w_dwell_clr ? 8'd0 : r_dwell + 8'(w_dwell_inc);
            r_state <= w_next;
        end
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wptr] <= bus.wr_char;
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_dwell_clr = 1'b0;
        w_dwell_inc = 1'b0;
        if (ena)
            case (r_state)
                IDLE: if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ISSUE;
                end
                ISSUE: if (bus.anim_ready) w_next = ANIM1;
                // The animator still shows ready during the cycle right after accept.
                ANIM1: w_next = ANIM;
                ANIM: if (bus.anim_ready) begin
                    w_next      = DWELL;
                    w_dwell_clr = 1'b1;
                end
                DWELL: if (tick60) begin
                    if (r_dwell == 8'(DWELL_TICKS - 1)) begin
                        w_pop = !w_empty;
`ifdef SEQ_LOOP_EN
                        w_next = ISSUE;
`else
                        w_next = w_empty ? IDLE : ISSUE;
`endif
                    end else w_dwell_inc = 1'b1;
                end
                default: w_next = IDLE;
            endcase
    end
    assign bus.char_valid = ena & (r_state == ISSUE);
    assign bus.char_out   = r_char;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_empty = w_empty;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_segment_char_sequencer.sv
// tb_segment_char_sequencer: directed checks of write sync, FIFO overflow, dwell timing and enable gating.
module tb_segment_char_sequencer;
    localparam int DEPTH = 4, DWELL = 3, SYNC = 2;
`ifdef SEQ_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, tick60 = 1'b0;
    int   n_pass = 0, n_total = 0;
    segment_char_sequencer_if bus();
    segment_char_sequencer #(.DEPTH(DEPTH), .DWELL_TICKS(DWELL), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick60(tick60), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic tick();
        tick60 = 1'b1;
        @(negedge clk);
        tick60 = 1'b0;
    endtask
    task automatic push(input logic [6:0] c);
        bus.wr_char   = c;
        bus.wr_strobe = 1'b1;
        cyc(4);
        bus.wr_strobe = 1'b0;
        cyc(3);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick60 = 1'b0;
        ena = 1'b1;
        bus.wr_strobe = 1'b0;
        bus.anim_ready = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask
    // Walk one character through accept, animation and a full dwell.
    task automatic run_one();
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        cyc(1);
        bus.anim_ready = 1'b1;
        cyc(1);
        repeat (DWELL) tick();
    endtask
    initial begin
        logic [6:0] exp_seq [4];
        exp_seq[0] = 7'h02; exp_seq[1] = 7'h03; exp_seq[2] = 7'h04; exp_seq[3] = 7'h0A;
        bus.wr_strobe = 1'b0;
        bus.wr_char = '0;
        bus.anim_ready = 1'b0;
        cyc(2);
        check("rst_valid", bus.char_valid, 0);
        check("rst_empty", bus.fifo_empty, 1);
        check("rst_full", bus.fifo_full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_char", bus.char_out, 0);
        rst_n = 1'b1;
        cyc(1);
        // reset asserted while the FSM waits in ANIM with a queued char
        push(7'h55);
        check("a_issue", bus.char_valid, 1);
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        push(7'h66);
        check("a_queued", bus.fifo_empty, 0);
        #2 rst_n = 1'b0;
        #1;
        check("a_rst_valid", bus.char_valid, 0);
        check("a_rst_empty", bus.fifo_empty, 1);
        check("a_rst_ovf", bus.overflow, 0);
        check("a_rst_char", bus.char_out, 0);
        do_reset();
        // single character latency and dwell
        bus.anim_ready = 1'b1;
        bus.wr_char = 7'h3A;
        bus.wr_strobe = 1'b1;
        cyc(SYNC + 1);
        check("s_early_valid", bus.char_valid, 0);
        check("s_pushed", bus.fifo_empty, 0);
        cyc(1);
        check("s_valid", bus.char_valid, 1);
        check("s_char", bus.char_out, 7'h3A);
        check("s_popped", bus.fifo_empty, 1);
        cyc(1);
        bus.anim_ready = 1'b0;
        bus.wr_strobe = 1'b0;
        check("s_accepted", bus.char_valid, 0);
        cyc(100);
        check("s_anim_wait", bus.char_valid, 0);
        bus.anim_ready = 1'b1;
        cyc(1);
        repeat (DWELL - 1) tick();
        check("s_dwell_short", bus.char_valid, 0);
        tick();
        check("s_dwell_end", bus.char_valid, LOOP);
        check("s_char_kept", bus.char_out, 7'h3A);
        do_reset();
        // full FIFO, push coinciding with the dwell-end pop, then overflow
        push(7'h7F);
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(7'(i));
        check("f_full", bus.fifo_full, 1);
        check("f_no_ovf", bus.overflow, 0);
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        repeat (DWELL - 1) tick();
        check("f_dwell_short", bus.char_valid, 0);
        bus.wr_char = 7'h0A;
        bus.wr_strobe = 1'b1;
        cyc(SYNC);
        tick();
        check("f_pop_valid", bus.char_valid, 1);
        check("f_pop_char", bus.char_out, 7'h01);
        check("f_still_full", bus.fifo_full, 1);
        check("f_pushpop_ovf", bus.overflow, 0);
        bus.wr_strobe = 1'b0;
        cyc(3);
        push(7'h05);
        check("o_full", bus.fifo_full, 1);
        check("o_ovf", bus.overflow, 1);
        for (int i = 0; i < 4; i++) begin
            run_one();
            check($sformatf("o_order%0d_valid", i), bus.char_valid, 1);
            check($sformatf("o_order%0d_char", i), bus.char_out, exp_seq[i]);
        end
        run_one();
        check("o_end_valid", bus.char_valid, LOOP);
        check("o_end_char", bus.char_out, 7'h0A);
        check("o_end_empty", bus.fifo_empty, 1);
        check("o_ovf_sticky", bus.overflow, 1);
        do_reset();
        // enable gating during DWELL and ISSUE
        push(7'h21);
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        cyc(1);
        bus.anim_ready = 1'b1;
        cyc(1);
        bus.anim_ready = 1'b0;
        push(7'h22);
        tick();
        ena = 1'b0;
        push(7'h23);
        repeat (10) tick();
        ena = 1'b1;
        tick();
        check("e_hold_count", bus.char_valid, 0);
        tick();
        check("e_resume_valid", bus.char_valid, 1);
        check("e_resume_char", bus.char_out, 7'h22);
        check("e_push_ignored", bus.fifo_empty, 1);
        ena = 1'b0;
        cyc(1);
        check("e_forced_low", bus.char_valid, 0);
        ena = 1'b1;
        cyc(1);
        check("e_reenabled", bus.char_valid, 1);
        do_reset();
        // looping re-issue and takeover by a new char
        bus.anim_ready = 1'b1;
        push(7'h11);
        repeat (DWELL) tick();
        check("l_first_end", bus.char_valid, LOOP);
        check("l_first_char", bus.char_out, 7'h11);
        cyc(3);
        push(7'h22);
        repeat (DWELL) tick();
        check("l_new_valid", bus.char_valid, LOOP);
        check("l_new_char", bus.char_out, 7'h22);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
